id_issue_ctrl: RTL and testbench

- Issue/interlock controller for the decode stage.
- Consumes decoded source addresses, the selected destination address and a latency class. Decides each cycle whether the instruction in ID issues or stalls.
- Keeps a per-GPR pending-write scoreboard for load results.
- Sequences the multi-cycle mul/div unit through a small FSM, including start, HI/LO writeback and cancel.

---
 rtl/id_issue_ctrl.sv | 96 +++++++++
 tb/tb_id_issue_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl: decode-stage issue/interlock with load scoreboard and mul/div sequencer
module id_issue_ctrl #(
  parameter int GPR_ADR  = 5,
  parameter int GPR_NUM  = 32,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 2,
  parameter int MD_LAT   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic               id_flush,
  input  logic [GPR_ADR-1:0] id_rs,
  input  logic [GPR_ADR-1:0] id_rt,
  input  logic               id_use_rs,
  input  logic               id_use_rt,
  input  logic               id_wr_en,
  input  logic [GPR_ADR-1:0] id_wr_addr,
  input  logic [1:0]         id_class,
  input  logic               id_use_hilo,
  input  logic               md_cancel,
  output logic               id_stall,
  output logic               id_issue,
  output logic               md_start,
  output logic               md_busy,
  output logic               md_done,
  output logic [GPR_NUM-1:0] sb_busy
);
  localparam int MD_W = MD_LAT > 1 ? $clog2(MD_LAT) : 1;
  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt [GPR_NUM];
  logic [MD_W-1:0] md_cnt;
  logic raw_a, raw_b, waw, hilo, strct, ld_set, md_go;
  always_comb begin
    raw_a = id_use_rs && id_rs != '0 && cnt[id_rs] != '0;
    raw_b = id_use_rt && id_rt != '0 && cnt[id_rt] != '0;
    waw = id_wr_en && id_wr_addr != '0 && cnt[id_wr_addr] != '0;
    hilo = id_use_hilo && state != IDLE;
    strct = id_class == 2'd2 && state != IDLE;
    id_stall = id_valid && !id_flush && (raw_a || raw_b || waw || hilo || strct);
    id_issue = id_valid && !id_flush && !id_stall;
    ld_set = id_issue && id_class == 2'd1 && id_wr_en && id_wr_addr != '0;
    md_go = id_issue && id_class == 2'd2;
    for (int i = 0; i < GPR_NUM; i++) sb_busy[i] = cnt[i] != '0;
  end
  // r0 is only ever written by reset, so it stays clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < GPR_NUM; i++) cnt[i] <= '0;
    end else begin
      for (int i = 1; i < GPR_NUM; i++)
        cnt[i] <= (ld_set && id_wr_addr == GPR_ADR'(i)) ? CNT_W'(LOAD_LAT) :
                  cnt[i] != '0 ? cnt[i] - CNT_W'(1) : cnt[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      md_cnt <= '0;
      md_start <= 1'b0;
      md_busy <= 1'b0;
      md_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= md_go ? RUN : IDLE;
          md_cnt <= md_go ? MD_W'(MD_LAT - 1) : '0;
          md_start <= md_go;
          md_busy <= md_go;
          md_done <= 1'b0;
        end
        RUN: begin
          md_start <= 1'b0;
          if (md_cancel) begin
            state <= IDLE;
            md_cnt <= '0;
            md_busy <= 1'b0;
          end else if (md_cnt == '0) begin
            state <= WB;
            md_done <= 1'b1;
          end else begin
            md_cnt <= md_cnt - MD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          md_cnt <= '0;
          md_start <= 1'b0;
          md_busy <= 1'b0;
          md_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_id_issue_ctrl.sv
// tb_id_issue_ctrl: directed checks of interlocks, load scoreboard and mul/div sequencing
module tb_id_issue_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid, id_flush, id_use_rs, id_use_rt, id_wr_en, id_use_hilo, md_cancel;
  logic [4:0] id_rs, id_rt, id_wr_addr;
  logic [1:0] id_class;
  logic id_stall, id_issue, md_start, md_busy, md_done;
  logic [31:0] sb_busy;
  int total = 0, bad = 0;
  logic seen;

  id_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_flush(id_flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_class(id_class),
    .id_use_hilo(id_use_hilo), .md_cancel(md_cancel), .id_stall(id_stall),
    .id_issue(id_issue), .md_start(md_start), .md_busy(md_busy), .md_done(md_done),
    .sb_busy(sb_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic we, input logic [4:0] wa,
                     input logic [1:0] cls, input logic hl);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_wr_en = we; id_wr_addr = wa; id_class = cls; id_use_hilo = hl;
    id_flush = 1'b0; md_cancel = 1'b0;
  endtask

  task automatic nop();   set(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic mult();  set(1, 1, 2, 1, 1, 0, 0, 2, 0); endtask
  task automatic mfhi();  set(1, 0, 0, 0, 0, 1, 3, 0, 1); endtask
  task automatic load(input logic [4:0] rd); set(1, 1, 0, 1, 0, 1, rd, 1, 0); endtask
  task automatic alu(input logic [4:0] rs, input logic [4:0] rt); set(1, rs, rt, 1, 1, 1, 4, 0, 0); endtask
  task automatic step(); @(negedge clk); endtask

  initial begin
    nop();
    #1;
    chk("rst_stall", id_stall, 0); chk("rst_issue", id_issue, 0);
    chk("rst_start", md_start, 0); chk("rst_busy", md_busy, 0);
    chk("rst_done", md_done, 0); chk("rst_sb", sb_busy, 0);
    step(); step(); rst_n = 1'b1;

    // load-use on rs
    step(); load(5); #1; chk("lu_t_issue", id_issue, 1);
    step(); alu(5, 6); #1; chk("lu_t1_stall", id_stall, 1); chk("lu_t1_sb", sb_busy, 32'h20);
    step(); #1; chk("lu_t2_issue", id_issue, 1); chk("lu_t2_sb", sb_busy, 0);
    // load-use on rt, then rs unused must not stall
    step(); load(8); #1; chk("rt_ld_issue", id_issue, 1);
    step(); alu(1, 8); #1; chk("rt_stall", id_stall, 1);
    step(); load(9); #1; chk("rt_ld9_issue", id_issue, 1);
    step(); set(1, 9, 0, 0, 0, 1, 4, 0, 0); #1; chk("unused_rs_issue", id_issue, 1);

    // register 0
    step(); load(0); #1; chk("r0_ld_issue", id_issue, 1);
    step(); alu(0, 0); #1; chk("r0_stall", id_stall, 0); chk("r0_sb", sb_busy, 0); chk("r0_issue", id_issue, 1);

    // flush with RAW present
    step(); load(5); #1; chk("fl_ld_issue", id_issue, 1);
    step(); alu(5, 0); id_flush = 1'b1; #1; chk("fl_stall", id_stall, 0); chk("fl_issue", id_issue, 0);
    // flushed MULT must not start the FSM
    step(); mult(); id_flush = 1'b1; #1; chk("fl_md_issue", id_issue, 0);
    step(); nop(); #1; chk("fl_md_busy", md_busy, 0); chk("fl_md_start", md_start, 0);

    // WAW between back-to-back loads
    step(); load(7); #1; chk("waw_t_issue", id_issue, 1);
    step(); load(7); #1; chk("waw_t1_stall", id_stall, 1); chk("waw_t1_sb", sb_busy, 32'h80);
    step(); #1; chk("waw_t2_issue", id_issue, 1);
    step(); nop(); #1; chk("waw_t3_sb", sb_busy, 32'h80);
    step(); #1; chk("waw_t4_sb", sb_busy, 0);

    // mult then mfhi
    step(); mult(); #1; chk("md_issue", id_issue, 1);
    for (int k = 1; k <= 34; k++) begin
      step(); mfhi(); #1;
      chk($sformatf("md_start_%0d", k), md_start, k == 1);
      chk($sformatf("md_done_%0d", k), md_done, k == 33);
      chk($sformatf("md_busy_%0d", k), md_busy, k <= 33);
      chk($sformatf("md_stall_%0d", k), id_stall, k <= 33);
      chk($sformatf("md_iss_%0d", k), id_issue, k == 34);
    end

    // structural: second mult presented from T+5
    step(); nop(); #1; chk("st_idle_busy", md_busy, 0);
    step(); mult(); #1; chk("st_issue", id_issue, 1);
    for (int k = 1; k <= 35; k++) begin
      step();
      if (k >= 5 && k <= 34) mult(); else nop();
      #1;
      chk($sformatf("st_start_%0d", k), md_start, k == 1 || k == 35);
      if (k >= 5 && k <= 34) begin
        chk($sformatf("st_stall_%0d", k), id_stall, k <= 33);
        chk($sformatf("st_iss_%0d", k), id_issue, k == 34);
      end
    end
    for (int k = 0; k < 34; k++) begin step(); nop(); end
    #1; chk("st_drain_busy", md_busy, 0);

    // cancel at T+10 with pending mfhi
    step(); mult(); #1; chk("cn_issue", id_issue, 1);
    for (int k = 1; k <= 12; k++) begin
      step(); mfhi(); md_cancel = (k == 10); #1;
      chk($sformatf("cn_done_%0d", k), md_done, 0);
      chk($sformatf("cn_busy_%0d", k), md_busy, k <= 10);
      chk($sformatf("cn_iss_%0d", k), id_issue, k >= 11);
    end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin step(); nop(); #1; seen |= md_done; end
    chk("cn_no_done", seen, 0);

    // md_cancel in IDLE together with a MULT issue: issue wins
    step(); mult(); md_cancel = 1'b1; #1; chk("ci_issue", id_issue, 1);
    step(); nop(); #1; chk("ci_start", md_start, 1); chk("ci_busy", md_busy, 1);
    step(); md_cancel = 1'b1; #1;
    step(); nop(); #1; chk("ci_cancel_busy", md_busy, 0);

    // async reset mid-RUN with a pending load
    step(); mult(); #1; chk("rr_issue", id_issue, 1);
    step(); load(9); #1; chk("rr_ld_issue", id_issue, 1);
    step(); nop(); #1; chk("rr_pre_busy", md_busy, 1); chk("rr_pre_sb", sb_busy, 32'h200);
    #2; rst_n = 1'b0; #1;
    chk("rr_busy", md_busy, 0); chk("rr_start", md_start, 0);
    chk("rr_done", md_done, 0); chk("rr_sb", sb_busy, 0); chk("rr_stall", id_stall, 0);
    step(); rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin step(); #1; seen |= md_done | md_busy; end
    chk("rr_no_done", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
